// File: rtl/gforce_pkg.sv
// Shared definitions for the instruction issue path: FSM encoding, halt sentinel
// and the MIPS opcodes that benches use to assemble programs.
package gforce_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    HALTED = 3'd4
  } issue_state_t;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

endpackage

// File: rtl/instr_store.sv
// Single-port program store: synchronous write and read; a write returns the
// written word on the read port.
module instr_store #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/instr_issuer.sv
// Instruction issue sequencer: walks a PC through the program store and presents
// each word on instrword with a one-cycle newinstr strobe, spaced by ISSUE_GAP.
module instr_issuer
  import gforce_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter int          ISSUE_GAP = 4,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data,
  input  logic                     start,
  output logic [31:0]              instrword,
  output logic                     newinstr,
  output logic [31:0]              pc,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              issued_count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [7:0]    GAP_LOAD = (ISSUE_GAP == 0) ? 8'd0 : 8'(ISSUE_GAP - 1);

  issue_state_t  state;
  logic [7:0]    gap_cnt;
  logic [31:0]   word_p1;
  logic [31:0]   last_word;
  logic [AW-1:0] pc_idx;
  logic          store_we;
  logic          is_halt;

  assign pc_idx   = pc[AW+1:2];
  assign store_we = load_en && (state == IDLE || state == HALTED);

  // Stage p1: word fetched during FETCH is available in the ISSUE cycle.
  instr_store #(.DEPTH(DEPTH)) u_store (
    .clock (clock),
    .we    (store_we),
    .addr  (store_we ? load_addr : pc_idx),
    .wdata (load_data),
    .rdata (word_p1)
  );

  assign is_halt   = (word_p1 == HALT_WORD);
  assign newinstr  = (state == ISSUE) && !is_halt;
  assign instrword = newinstr ? word_p1 : last_word;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      issued_count <= '0;
      gap_cnt      <= '0;
      last_word    <= '0;
    end else begin
      unique case (state)
        IDLE, HALTED: begin
          // A simultaneous load wins over start.
          if (!load_en && start) begin
            pc           <= '0;
            issued_count <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            state        <= FETCH;
          end
        end
        FETCH: state <= ISSUE;
        ISSUE: begin
          if (is_halt) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= HALTED;
          end else begin
            last_word <= word_p1;
            if (issued_count != 16'hFFFF) issued_count <= issued_count + 16'd1;
            if (pc_idx == LAST_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= HALTED;
            end else if (ISSUE_GAP == 0) begin
              pc    <= pc + 32'd4;
              state <= FETCH;
            end else begin
              gap_cnt <= GAP_LOAD;
              state   <= WAIT;
            end
          end
        end
        WAIT: begin
          if (gap_cnt == 8'd0) begin
            pc    <= pc + 32'd4;
            state <= FETCH;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_issuer.sv
// Bench for instr_issuer: three instances (gap 4, gap 0, depth 4) driven with
// directed and random programs, checked against a program-walk reference model.
module tb_instr_issuer;
  import gforce_pkg::*;

  localparam int N = 3;
  localparam int DEPTHS [N] = '{16, 16, 4};
  localparam int GAPS   [N] = '{4, 0, 2};
  localparam logic [31:0] HW = HALT_WORD_DEFAULT;

  typedef struct {
    logic [31:0] w;
    logic [31:0] pc;
    int          cyc;
  } strobe_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_en      [N];
  logic [9:0]  load_addr    [N];
  logic [31:0] load_data    [N];
  logic        start        [N];
  logic [31:0] instrword    [N];
  logic        newinstr     [N];
  logic [31:0] pc           [N];
  logic        busy         [N];
  logic        done         [N];
  logic [15:0] issued_count [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    instr_issuer #(.DEPTH(DEPTHS[g]), .ISSUE_GAP(GAPS[g]), .HALT_WORD(HW)) u_dut (
      .clock        (clock),
      .reset        (reset),
      .load_en      (load_en[g]),
      .load_addr    (load_addr[g][$clog2(DEPTHS[g])-1:0]),
      .load_data    (load_data[g]),
      .start        (start[g]),
      .instrword    (instrword[g]),
      .newinstr     (newinstr[g]),
      .pc           (pc[g]),
      .busy         (busy[g]),
      .done         (done[g]),
      .issued_count (issued_count[g])
    );
  end

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int          ntot = 0;
  int          nbad = 0;
  logic [31:0] model_mem   [N][16];
  logic [31:0] last_issued [N];
  strobe_t     exp_q [$];
  logic [31:0] exp_pc;
  strobe_t     mon_q [N][$];
  logic        prev_ni [N];
  int          consec  [N] = '{default: 0};

  always @(negedge clock) begin : monitor
    strobe_t s;
    for (int k = 0; k < N; k++) begin
      if (newinstr[k] === 1'b1) begin
        s.w = instrword[k]; s.pc = pc[k]; s.cyc = cyc;
        mon_q[k].push_back(s);
        if (prev_ni[k] === 1'b1) consec[k]++;
      end
      prev_ni[k] = newinstr[k];
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic load_word(input int k, input int a, input logic [31:0] d);
    load_en[k] = 1'b1; load_addr[k] = 10'(a); load_data[k] = d;
    tick();
    load_en[k] = 1'b0;
    model_mem[k][a] = d;
  endtask

  task automatic pulse_start(input int k, output int s0);
    mon_q[k].delete();
    s0 = cyc;
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (done[k] === 1'b1) begin ok = 1'b1; return; end
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [5:0] op;
    case ($urandom_range(2))
      0:       op = OP_RTYPE;
      1:       op = OP_LW;
      default: op = OP_SW;
    endcase
    return {op, 26'($urandom)};
  endfunction

  // Reference: walk the program from index 0, one strobe per non-halt word,
  // stopping at the sentinel or after the last store word.
  task automatic build_expect(input int k, input int s0);
    strobe_t e;
    exp_q.delete();
    exp_pc = 32'd0;
    for (int i = 0; i < DEPTHS[k]; i++) begin
      exp_pc = 32'(i * 4);
      if (model_mem[k][i] == HW) break;
      e.w = model_mem[k][i]; e.pc = 32'(i * 4);
      e.cyc = s0 + 2 + exp_q.size() * (GAPS[k] + 2);
      exp_q.push_back(e);
    end
    if (exp_q.size() > 0) last_issued[k] = exp_q[exp_q.size()-1].w;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int k = 0; k < N; k++) begin
      load_en[k] = 1'b0; load_addr[k] = '0; load_data[k] = '0; start[k] = 1'b0;
      last_issued[k] = '0;
    end
    repeat (3) tick();
    for (int k = 0; k < N; k++) begin
      ntot++;
      if ({instrword[k], newinstr[k], pc[k], busy[k], done[k], issued_count[k]} !== '0) begin
        nbad++;
        $display("FAIL reset_state[%0d] got iw=%h ni=%b pc=%h busy=%b done=%b cnt=%0d required all zero",
                 k, instrword[k], newinstr[k], pc[k], busy[k], done[k], issued_count[k]);
      end
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int s0; bit ok;
    load_word(0, 0, 32'h8C01_0000);
    load_word(0, 1, 32'h0022_1820);
    load_word(0, 2, HW);
    pulse_start(0, s0);
    build_expect(0, s0);
    wait_done(0, ok);
    ntot++;
    if (!ok) begin nbad++; $display("FAIL basic_done timeout done=%b required 1", done[0]); end
    ntot++;
    if (mon_q[0].size() != 2) begin
      nbad++; $display("FAIL basic_count got=%0d required=2", mon_q[0].size());
    end else begin
      ntot++;
      if (mon_q[0][0].w !== 32'h8C01_0000 || mon_q[0][0].pc !== 32'd0 || mon_q[0][0].cyc != s0 + 2) begin
        nbad++; $display("FAIL basic_first got w=%h pc=%0d cyc=%0d required w=8c010000 pc=0 cyc=%0d",
                         mon_q[0][0].w, mon_q[0][0].pc, mon_q[0][0].cyc, s0 + 2);
      end
      ntot++;
      if (mon_q[0][1].w !== 32'h0022_1820 || mon_q[0][1].pc !== 32'd4 || mon_q[0][1].cyc - mon_q[0][0].cyc != 6) begin
        nbad++; $display("FAIL basic_second got w=%h pc=%0d gap=%0d required w=00221820 pc=4 gap=6",
                         mon_q[0][1].w, mon_q[0][1].pc, mon_q[0][1].cyc - mon_q[0][0].cyc);
      end
    end
    ntot++;
    if (done[0] !== 1'b1 || busy[0] !== 1'b0 || issued_count[0] !== 16'd2 || pc[0] !== 32'd8 || instrword[0] !== 32'h0022_1820) begin
      nbad++; $display("FAIL basic_final got done=%b busy=%b cnt=%0d pc=%0d iw=%h required done=1 busy=0 cnt=2 pc=8 iw=00221820",
                       done[0], busy[0], issued_count[0], pc[0], instrword[0]);
    end
  endtask

  task automatic run_and_compare(input int k, input string tag);
    int s0; bit ok;
    pulse_start(k, s0);
    build_expect(k, s0);
    wait_done(k, ok);
    ntot++;
    if (!ok) begin nbad++; $display("FAIL %s_done timeout done=%b required 1", tag, done[k]); end
    ntot++;
    if (mon_q[k].size() != exp_q.size()) begin
      nbad++; $display("FAIL %s_count got=%0d required=%0d", tag, mon_q[k].size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < mon_q[k].size(); i++) begin
      ntot++;
      if (mon_q[k][i].w !== exp_q[i].w || mon_q[k][i].pc !== exp_q[i].pc || mon_q[k][i].cyc != exp_q[i].cyc) begin
        nbad++;
        $display("FAIL %s_strobe%0d got w=%h pc=%0d cyc=%0d required w=%h pc=%0d cyc=%0d", tag, i,
                 mon_q[k][i].w, mon_q[k][i].pc, mon_q[k][i].cyc, exp_q[i].w, exp_q[i].pc, exp_q[i].cyc);
      end
    end
    ntot++;
    if (done[k] !== 1'b1 || busy[k] !== 1'b0 || pc[k] !== exp_pc ||
        issued_count[k] !== 16'(exp_q.size()) || instrword[k] !== last_issued[k]) begin
      nbad++;
      $display("FAIL %s_final got done=%b busy=%b pc=%0d cnt=%0d iw=%h required done=1 busy=0 pc=%0d cnt=%0d iw=%h",
               tag, done[k], busy[k], pc[k], issued_count[k], instrword[k],
               exp_pc, exp_q.size(), last_issued[k]);
    end
  endtask

  task automatic test_gap_zero();
    for (int i = 0; i < 3; i++) load_word(1, i, rand_word());
    load_word(1, 3, HW);
    run_and_compare(1, "gap_zero");
  endtask

  task automatic test_end_of_store();
    for (int i = 0; i < 4; i++) load_word(2, i, rand_word());
    run_and_compare(2, "end_of_store");
  endtask

  task automatic test_busy_ignored();
    int s0; bit ok;
    logic [31:0] intruder;
    for (int i = 0; i < 6; i++) load_word(0, i, rand_word());
    load_word(0, 6, HW);
    intruder = ~model_mem[0][5];
    pulse_start(0, s0);
    build_expect(0, s0);
    repeat (4) tick();
    load_en[0] = 1'b1; load_addr[0] = 10'd5; load_data[0] = intruder; start[0] = 1'b1;
    tick();
    load_en[0] = 1'b0; start[0] = 1'b0;
    wait_done(0, ok);
    ntot++;
    if (!ok) begin nbad++; $display("FAIL busy_done timeout done=%b required 1", done[0]); end
    ntot++;
    if (mon_q[0].size() != exp_q.size()) begin
      nbad++; $display("FAIL busy_count got=%0d required=%0d", mon_q[0].size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < mon_q[0].size(); i++) begin
      ntot++;
      if (mon_q[0][i].w !== exp_q[i].w || mon_q[0][i].pc !== exp_q[i].pc || mon_q[0][i].cyc != exp_q[i].cyc) begin
        nbad++;
        $display("FAIL busy_strobe%0d got w=%h pc=%0d cyc=%0d required w=%h pc=%0d cyc=%0d", i,
                 mon_q[0][i].w, mon_q[0][i].pc, mon_q[0][i].cyc, exp_q[i].w, exp_q[i].pc, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_restart();
    int s0; bit ok;
    logic [31:0] fresh;
    fresh = rand_word();
    while (fresh == model_mem[0][0]) fresh = rand_word();
    load_word(0, 0, fresh);
    pulse_start(0, s0);
    build_expect(0, s0);
    ntot++;
    if (done[0] !== 1'b0 || busy[0] !== 1'b1) begin
      nbad++; $display("FAIL restart_leave_halt got done=%b busy=%b required done=0 busy=1", done[0], busy[0]);
    end
    tick();
    ntot++;
    if (newinstr[0] !== 1'b1 || instrword[0] !== fresh) begin
      nbad++; $display("FAIL restart_first got ni=%b iw=%h required ni=1 iw=%h", newinstr[0], instrword[0], fresh);
    end
    tick();
    ntot++;
    if (issued_count[0] !== 16'd1) begin
      nbad++; $display("FAIL restart_count got=%0d required=1", issued_count[0]);
    end
    wait_done(0, ok);
    ntot++;
    if (!ok || mon_q[0].size() != exp_q.size() || issued_count[0] !== 16'(exp_q.size())) begin
      nbad++; $display("FAIL restart_run got done=%b strobes=%0d cnt=%0d required done=1 strobes=%0d cnt=%0d",
                       done[0], mon_q[0].size(), issued_count[0], exp_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_midrun();
    int s0;
    for (int i = 0; i < 3; i++) load_word(0, i, rand_word());
    load_word(0, 3, HW);
    pulse_start(0, s0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    ntot++;
    if ({instrword[0], newinstr[0], pc[0], busy[0], done[0], issued_count[0]} !== '0) begin
      nbad++;
      $display("FAIL reset_midrun got iw=%h ni=%b pc=%h busy=%b done=%b cnt=%0d required all zero",
               instrword[0], newinstr[0], pc[0], busy[0], done[0], issued_count[0]);
    end
    reset = 1'b0;
    for (int k = 0; k < N; k++) last_issued[k] = '0;
    tick();
    run_and_compare(0, "after_reset");
  endtask

  task automatic test_random();
    for (int it = 0; it < 9; it++) begin
      int k, len;
      k = it % N;
      len = $urandom_range(DEPTHS[k]);
      for (int i = 0; i < len; i++) load_word(k, i, rand_word());
      if (len < DEPTHS[k]) load_word(k, len, HW);
      run_and_compare(k, $sformatf("random%0d", it));
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < N; k++) begin
      ntot++;
      if (consec[k] != 0) begin
        nbad++; $display("FAIL back_to_back[%0d] consecutive strobes got=%0d required=0", k, consec[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap_zero();
    test_end_of_store();
    test_busy_ignored();
    test_restart();
    test_reset_midrun();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule

// File: doc/instr_issuer.md
# instr_issuer

Instruction issue sequencer that drives the CPU core's instruction input. It holds a small program store loaded through a write port, and walks a program counter through it. Each word is presented on `instrword` with a one-cycle `newinstr` strobe, and successive strobes are spaced so the single-cycle datapath settles between them. It sits between the testbench/loader and `mipscpu` and is the producing end of the `instrword`/`newinstr` interface.

## Interface
- `DEPTH`, 64 — program store words; power of two, 2..1024
- `ISSUE_GAP`, 4 — idle cycles inserted after each strobe; 0..255
- `HALT_WORD`, 32'hFFFF_FFFF — sentinel word that ends the program without being issued
- `clock`  in  1  — single clock; all state changes on its rising edge
- `reset`  in  1  — synchronous, active-high
- `load_en`  in  1  — write `load_data` into store at `load_addr`
- `load_addr`  in  log2(DEPTH)  — store word index
- `load_data`  in  32  — instruction word to store
- `start`  in  1  — begin or restart execution at index 0
- `instrword`  out  32  — instruction presented to CPU
- `newinstr`  out  1  — one-cycle strobe: `instrword` is new this cycle
- `pc`  out  32  — byte address of current instruction (index × 4)
- `busy`  out  1  — high in FETCH, ISSUE, WAIT
- `done`  out  1  — high in HALTED
- `issued_count`  out  16  — number of strobes since last start; saturates at 16'hFFFF

## Operation
- Reset values: `instrword`=0, `newinstr`=0, `pc`=0, `busy`=0, `done`=0, `issued_count`=0, state IDLE. Store contents are not cleared by reset.
- States: IDLE, FETCH, ISSUE, WAIT, HALTED.
- IDLE:
  - `load_en` writes the store.
  - Otherwise, `start` clears `pc` and `issued_count` and goes to FETCH.
  - If `load_en` and `start` are high together, the load is performed and `start` is ignored.
- FETCH: synchronous read of store[`pc`/4]. Goes to ISSUE.
- ISSUE, when the read word equals `HALT_WORD`: go to HALTED. No strobe; `instrword` is unchanged.
- ISSUE, otherwise:
  - Register the word onto `instrword` and assert `newinstr` for exactly this cycle.
  - Increment `issued_count` (saturating).
  - If the index is DEPTH-1, go to HALTED after the strobe (end of store; no wrap-around).
  - Otherwise go to WAIT, or to FETCH with `pc`+=4 directly when `ISSUE_GAP`=0.
- WAIT: gap counter loaded with `ISSUE_GAP`-1 on entry and decrements each cycle. When it reaches 0, `pc`+=4 and go to FETCH.
- HALTED:
  - `done`=1.
  - `load_en` is accepted here.
  - `start` (without `load_en`) clears `pc` and `issued_count`, drops `done`, and goes to FETCH.
- `load_en` and `start` are ignored while `busy`.
- `instrword` holds its last issued value until the next ISSUE. `pc` holds the last issued or halted address in HALTED.
- `reset` asserted in any state overrides everything and returns to reset values next edge. A strobe in progress is not completed.

## Timing
- `start` sampled at edge t:
  - FETCH during cycle t+1.
  - First `newinstr` high during cycle t+2.
- Strobe period is `ISSUE_GAP`+2 cycles (ISSUE + `ISSUE_GAP` WAIT + FETCH).
- `newinstr` is never high on two consecutive cycles when `ISSUE_GAP`≥0.
- HALT detection: `done` rises the cycle after the ISSUE cycle that saw `HALT_WORD`.
- Load-to-read: a word written at edge t is visible to a FETCH at edge t+1 or later.
- `busy` and `done` are mutually exclusive and both registered.

## Structure
- Shared package (`gforce_pkg`) holds:
  - state encoding constants IDLE=0, FETCH=1, ISSUE=2, WAIT=3, HALTED=4 (3-bit);
  - default `HALT_WORD`;
  - MIPS opcode constants R-type=0, LW=35, SW=43, which benches reuse to build programs.
- One sub-module, `instr_store`: DEPTH×32 single-port RAM, synchronous write, synchronous read, write has priority on the same address.
- FSM, `pc`, gap counter, and `issued_count` live in `instr_issuer`.

## Test plan
- Basic program, `ISSUE_GAP`=4:
  - Stimulus: load [0]=32'h8C01_0000 (LW), [1]=32'h0022_1820 (ADD), [2]=`HALT_WORD`, then pulse `start`.
  - Required: two strobes 6 cycles apart with `instrword` 8C010000 then 00221820 and `pc` 0 then 4; `done` high; `issued_count`=2.
- Gap zero, `ISSUE_GAP`=0:
  - Stimulus: three non-halt words then `HALT_WORD`.
  - Required: strobes exactly 2 cycles apart; `issued_count`=3.
- End of store, `DEPTH`=4:
  - Stimulus: no `HALT_WORD` in the store.
  - Required: 4 strobes, last with `pc`=12, then HALTED; no wrap to index 0.
- Ignored inputs while busy:
  - Stimulus: `load_en` and `start` asserted mid-run.
  - Required: store unchanged; strobe sequence unchanged.
- Restart from HALTED:
  - Stimulus: load [0] with a new word while HALTED, then pulse `start`.
  - Required: the new word is issued first; `issued_count` restarts at 1.
- Reset mid-run:
  - Stimulus: assert `reset` during WAIT.
  - Required: all outputs 0 on the next cycle; store retained. A later `start` reissues from `pc`=0.
